// File: rtl/bmnc_pkg.sv
// Shared definitions for the bitonic-merge set engine: tagged width, mode codes and
// the width helper used to size the element count.
package bmnc_pkg;

   localparam logic MODE_INTERSECT = 1'b0;
   localparam logic MODE_UNION     = 1'b1;

   // Tagged element = {invalid flag, value}
   function automatic int tag_w(input int ew);
      return ew + 1;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/bmnc_cas_stage.sv
// One registered compare-and-swap layer of the bitonic half-cleaner network; pairs
// (i, i+DIST) with bit DIST of i clear, smaller element goes to the lower slot.
module bmnc_cas_stage import bmnc_pkg::*; #(
   parameter int N2   = 16,
   parameter int DIST = 8,
   parameter int EW1  = 17
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     en_i,
   input  logic                     vld_i,
   input  logic                     mode_i,
   input  logic [N2-1:0][EW1-1:0]   data_i,
   output logic                     vld_o,
   output logic                     mode_o,
   output logic [N2-1:0][EW1-1:0]   data_o
);

   logic [EW1-1:0] data_d [N2];
   logic [N2-1:0][EW1-1:0] data_q;
   logic vld_q, mode_q;

   for (genvar i = 0; i < N2; i++) begin : g_cas
      if (((i / DIST) % 2) == 0) begin : g_pair
         logic swap;
         assign swap = data_i[i] > data_i[i+DIST];
         assign data_d[i]      = swap ? data_i[i+DIST] : data_i[i];
         assign data_d[i+DIST] = swap ? data_i[i]      : data_i[i+DIST];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vld_q <= 1'b0;
      end else if (en_i) begin
         vld_q  <= vld_i;
         mode_q <= mode_i;
         for (int i = 0; i < N2; i++) data_q[i] <= data_d[i];
      end
   end

   assign vld_o  = vld_q;
   assign mode_o = mode_q;
   assign data_o = data_q;

endmodule

// File: rtl/bmnc_stream_setop.sv
// Streaming set engine: bitonic merge of two sorted lists, neighbour-equality check,
// then compaction into a left-aligned intersection or de-duplicated union.
module bmnc_stream_setop import bmnc_pkg::*; #(
   parameter  int N     = 8,
   parameter  int LOG_N = 3,
   parameter  int EW    = 16,
   localparam int CW    = clog2(2*N + 1)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic                in_mode_i,
   input  logic [N*EW-1:0]     in_a_i,
   input  logic [N-1:0]        in_a_mask_i,
   input  logic [N*EW-1:0]     in_b_i,
   input  logic [N-1:0]        in_b_mask_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [2*N*EW-1:0]   out_data_o,
   output logic [2*N-1:0]      out_mask_o,
   output logic [CW-1:0]       out_count_o
);

   localparam int N2     = 2 * N;
   localparam int EW1    = tag_w(EW);
   localparam int STAGES = LOG_N + 1;

   logic en;
   logic out_valid_q;
   logic [STAGES:0] vld_pipe, mode_pipe;
   logic [N2-1:0][EW1-1:0] sdat [STAGES+1];

   assign en         = !out_valid_q || out_ready_i;
   assign in_ready_o = en;

   // Invalid slots get a zero payload so each half stays monotonic and the
   // concatenation is truly bitonic; tagged slots are never kept, so no value is lost.
   always_comb begin
      sdat[0] = '0;
      for (int i = 0; i < N; i++) begin
         sdat[0][i]      = in_a_mask_i[i] ? {1'b0, in_a_i[i*EW +: EW]} : {1'b1, {EW{1'b0}}};
         sdat[0][N2-1-i] = in_b_mask_i[i] ? {1'b0, in_b_i[i*EW +: EW]} : {1'b1, {EW{1'b0}}};
      end
   end
   assign vld_pipe[0]  = in_valid_i;
   assign mode_pipe[0] = in_mode_i;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      bmnc_cas_stage #(.N2(N2), .DIST(N >> s), .EW1(EW1)) u_cas (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .en_i    (en),
         .vld_i   (vld_pipe[s]),
         .mode_i  (mode_pipe[s]),
         .data_i  (sdat[s]),
         .vld_o   (vld_pipe[s+1]),
         .mode_o  (mode_pipe[s+1]),
         .data_o  (sdat[s+1])
      );
   end

   // Neighbourhood check
   logic [N2-1:0] tag, eq, eq_prev, keep_d, chk_keep_q;
   logic [N2-1:0][EW-1:0] chk_dat_d, chk_dat_q;
   logic chk_vld_q;

   always_comb begin
      tag       = '0;
      eq        = '0;
      chk_dat_d = '0;
      for (int i = 0; i < N2; i++) begin
         tag[i]       = sdat[STAGES][i][EW1-1];
         chk_dat_d[i] = sdat[STAGES][i][EW-1:0];
      end
      for (int i = 0; i < N2-1; i++)
         eq[i] = (sdat[STAGES][i] == sdat[STAGES][i+1]) && !tag[i] && !tag[i+1];
      eq_prev = {eq[N2-2:0], 1'b0};
      keep_d  = (mode_pipe[STAGES] == MODE_UNION) ? (~tag & ~eq_prev) : eq;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         chk_vld_q <= 1'b0;
      end else if (en) begin
         chk_vld_q  <= vld_pipe[STAGES];
         chk_keep_q <= keep_d;
         chk_dat_q  <= chk_dat_d;
      end
   end

   // Compaction: running keep count is the destination slot
   logic [N2-1:0][EW-1:0] out_data_d, out_data_q;
   logic [N2-1:0]         out_mask_d, out_mask_q;
   logic [CW-1:0]         out_count_d, out_count_q;
   logic [LOG_N:0]        idx;

   always_comb begin
      out_data_d  = '0;
      out_mask_d  = '0;
      out_count_d = '0;
      idx         = '0;
      for (int i = 0; i < N2; i++) begin
         if (chk_keep_q[i]) begin
            out_data_d[idx] = chk_dat_q[i];
            out_mask_d[idx] = 1'b1;
            idx             = idx + 1'b1;
            out_count_d     = out_count_d + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mask_q  <= '0;
         out_count_q <= '0;
      end else if (en) begin
         out_valid_q <= chk_vld_q;
         out_data_q  <= out_data_d;
         out_mask_q  <= out_mask_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_mask_o  = out_mask_q;
   assign out_count_o = out_count_q;

endmodule
